tdm_mux_rr: RTL and testbench



---
 rtl/tdm_mux_pkg.sv | 31 +++
 rtl/tdm_mux_rr_rr_pick.sv | 31 +++
 rtl/tdm_mux_rr.sv | 104 ++++++++++
 tb/tb_tdm_mux_rr.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_mux_pkg.sv
// Shared types and helpers for the tdm_mux_rr channel multiplexer.
// Optional feature macro: TDM_MUX_PARITY_EN (parity bit alongside each beat).
package tdm_mux_pkg;

    // Selection policy applied at each load decision
    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    // Widest data word the parity helper accepts
    localparam int MAX_W = 64;

    // Number of bits needed to index n channels, never less than one
    function automatic int sel_width(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << w) < n) begin
                w = w + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

    // Even parity bit: makes the total count of ones (data plus bit) even
    function automatic logic even_parity(input logic [MAX_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/tdm_mux_rr_rr_pick.sv
// Rotating-priority finder: first asserted request at or after ptr, wrapping.
module rr_pick #(
    parameter int N    = 16,
    parameter int SELW = 4
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic            found,
    output logic [SELW-1:0] idx
);

    int k;

    // Walk the channels starting at ptr and keep the first one that requests
    always_comb begin
        found = 1'b0;
        idx   = '0;
        k     = 0;
        for (int i = 0; i < N; i++) begin
            k = int'(ptr) + i;
            if (k >= N) begin
                k = k - N;
            end
            if (!found && req[k]) begin
                found = 1'b1;
                idx   = SELW'(k);
            end
        end
    end

endmodule

// File: rtl/tdm_mux_rr.sv
// Registered N:1 channel multiplexer with direct-select and round-robin scan
// modes, a single output beat under valid/ready, and per-channel acknowledge.
// Optional feature macro: TDM_MUX_PARITY_EN adds out_par (even parity of out).
module tdm_mux_rr
    import tdm_mux_pkg::*;
#(
    parameter int N    = 16,
    parameter int W    = 8,
    parameter int SELW = tdm_mux_pkg::sel_width(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N*W-1:0]  in,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ack,
    input  logic [SELW-1:0] sel1,
    input  logic            mode,
    output logic [W-1:0]    out,
    output logic [SELW-1:0] out_ch,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            sel_err
`ifdef TDM_MUX_PARITY_EN
    ,
    output logic            out_par
`endif
);

    logic [(2**SELW)-1:0] valid_pad;
    logic                 sel_in_range;
    logic                 scan_found;
    logic [SELW-1:0]      scan_idx;
    logic                 cand_found;
    logic [SELW-1:0]      cand_idx;
    logic [W-1:0]         cand_data;
    logic                 load_ok;
    logic                 load;
    logic [SELW-1:0]      ptr;
    logic [SELW-1:0]      ptr_next;

    rr_pick #(
        .N    (N),
        .SELW (SELW)
    ) u_pick (
        .req   (in_valid),
        .ptr   (ptr),
        .found (scan_found),
        .idx   (scan_idx)
    );

    // Choose this cycle's candidate, decide whether the output slot is free, and acknowledge the winner
    always_comb begin
        valid_pad          = '0;
        valid_pad[N-1:0]   = in_valid;
        sel_in_range       = (int'(sel1) < N);
        if (mode == MODE_SCAN) begin
            cand_found = scan_found;
            cand_idx   = scan_idx;
        end else begin
            cand_found = sel_in_range && valid_pad[sel1];
            cand_idx   = cand_found ? sel1 : '0;
        end
        load_ok   = !out_valid || out_ready;
        load      = load_ok && cand_found;
        cand_data = in[int'(cand_idx)*W +: W];
        ptr_next  = (int'(cand_idx) == N - 1) ? '0 : cand_idx + SELW'(1);
        in_ack    = '0;
        if (load) begin
            in_ack[cand_idx] = 1'b1;
        end
    end

    // Output beat register, scan pointer and select-error flag; reset drops any held beat
    always_ff @(posedge clk) begin
        if (reset) begin
            out       <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            sel_err   <= 1'b0;
            ptr       <= '0;
`ifdef TDM_MUX_PARITY_EN
            out_par   <= 1'b0;
`endif
        end else begin
            sel_err <= (mode == MODE_DIRECT) && !sel_in_range;
            if (load_ok) begin
                if (cand_found) begin
                    out       <= cand_data;
                    out_ch    <= cand_idx;
                    out_valid <= 1'b1;
`ifdef TDM_MUX_PARITY_EN
                    out_par   <= even_parity(MAX_W'(cand_data));
`endif
                    if (mode == MODE_SCAN) begin
                        ptr <= ptr_next;
                    end
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_tdm_mux_rr.sv
// Directed self-checking bench for tdm_mux_rr (N=16 main instance, N=12 for
// out-of-range select). Build with TDM_MUX_PARITY_EN to exercise out_par.
module tb_tdm_mux_rr;

    logic         clk;
    logic         reset;
    logic [127:0] in_bus;
    logic [7:0]   lane [16];
    logic [15:0]  in_valid;
    logic [15:0]  in_ack;
    logic [3:0]   sel1;
    logic         mode;
    logic [7:0]   out;
    logic [3:0]   out_ch;
    logic         out_valid;
    logic         out_ready;
    logic         sel_err;

    logic [11:0]  in_ack12;
    logic [7:0]   out12;
    logic [3:0]   out_ch12;
    logic         out_valid12;
    logic         sel_err12;

`ifdef TDM_MUX_PARITY_EN
    logic         out_par;
    logic         out_par12;
`endif

    int errors = 0;
    int checks = 0;
    logic [3:0] scan_seq [6];

    tdm_mux_rr #(.N(16), .W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in_bus),
        .in_valid  (in_valid),
        .in_ack    (in_ack),
        .sel1      (sel1),
        .mode      (mode),
        .out       (out),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel_err   (sel_err)
`ifdef TDM_MUX_PARITY_EN
        ,
        .out_par   (out_par)
`endif
    );

    tdm_mux_rr #(.N(12), .W(8)) dut12 (
        .clk       (clk),
        .reset     (reset),
        .in        (in_bus[95:0]),
        .in_valid  (in_valid[11:0]),
        .in_ack    (in_ack12),
        .sel1      (sel1),
        .mode      (mode),
        .out       (out12),
        .out_ch    (out_ch12),
        .out_valid (out_valid12),
        .out_ready (out_ready),
        .sel_err   (sel_err12)
`ifdef TDM_MUX_PARITY_EN
        ,
        .out_par   (out_par12)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pack the per-lane bytes onto the flat input bus
    always_comb begin
        in_bus = '0;
        for (int k = 0; k < 16; k++) begin
            in_bus[k*8 +: 8] = lane[k];
        end
    end

    // Hard stop if the directed sequence ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] s, input logic [15:0] v, input logic m, input logic rdy);
        sel1      = s;
        in_valid  = v;
        mode      = m;
        out_ready = rdy;
        #1;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 16; k++) lane[k] = 8'h10 + 8'(k);
        scan_seq[0] = 4'd0;  scan_seq[1] = 4'd2;  scan_seq[2] = 4'd15;
        scan_seq[3] = 4'd0;  scan_seq[4] = 4'd2;  scan_seq[5] = 4'd15;
        reset = 1'b1;
        applyStimulus(4'd0, 16'h0000, 1'b0, 1'b1);
        stepClock();
        stepClock();

        checkOutput("reset_out",       32'(out),       32'h0);
        checkOutput("reset_out_ch",    32'(out_ch),    32'h0);
        checkOutput("reset_out_valid", 32'(out_valid), 32'h0);
        checkOutput("reset_sel_err",   32'(sel_err),   32'h0);
        checkOutput("reset_in_ack",    32'(in_ack),    32'h0);
`ifdef TDM_MUX_PARITY_EN
        checkOutput("reset_out_par",   32'(out_par),   32'h0);
`endif
        reset = 1'b0;

        // Direct sweep over every channel
        for (int s = 0; s < 16; s++) begin
            applyStimulus(4'(s), 16'hFFFF, 1'b0, 1'b1);
            checkOutput("sweep_ack",    32'(in_ack),    32'(16'h0001 << s));
            stepClock();
            checkOutput("sweep_out",    32'(out),       32'(8'h10 + 8'(s)));
            checkOutput("sweep_out_ch", 32'(out_ch),    32'(s));
            checkOutput("sweep_valid",  32'(out_valid), 32'h1);
        end

        // Backpressure: capture lane 3, then stall while it changes
        lane[3] = 8'hA0;
        applyStimulus(4'd3, 16'hFFFF, 1'b0, 1'b1);
        stepClock();
        checkOutput("bp_first_out", 32'(out), 32'hA0);
        for (int c = 1; c <= 4; c++) begin
            lane[3] = 8'hA0 + 8'(c);
            applyStimulus(4'd3, 16'hFFFF, 1'b0, 1'b0);
            checkOutput("bp_ack_quiet", 32'(in_ack), 32'h0);
            stepClock();
            checkOutput("bp_out_frozen", 32'(out),       32'hA0);
            checkOutput("bp_valid_held", 32'(out_valid), 32'h1);
        end
        lane[3] = 8'hA5;
        applyStimulus(4'd3, 16'hFFFF, 1'b0, 1'b1);
        checkOutput("bp_release_ack", 32'(in_ack), 32'h0008);
        stepClock();
        checkOutput("bp_release_out", 32'(out), 32'hA5);
        lane[3] = 8'h13;

        // Scan wrap over channels 0, 2, 15
        for (int i = 0; i < 6; i++) begin
            applyStimulus(4'd0, 16'h8005, 1'b1, 1'b1);
            checkOutput("scan_ack", 32'(in_ack), 32'(16'h0001 << scan_seq[i]));
            stepClock();
            checkOutput("scan_out_ch", 32'(out_ch), 32'(scan_seq[i]));
            checkOutput("scan_out",    32'(out),    32'(8'h10 + 8'(scan_seq[i])));
        end

        // Scan with nothing valid, then a lone channel 8
        for (int i = 0; i < 2; i++) begin
            applyStimulus(4'd0, 16'h0000, 1'b1, 1'b1);
            checkOutput("empty_ack", 32'(in_ack), 32'h0);
            stepClock();
            checkOutput("empty_valid",  32'(out_valid), 32'h0);
            checkOutput("empty_out_ch", 32'(out_ch),    32'd15);
        end
        applyStimulus(4'd0, 16'h0100, 1'b1, 1'b1);
        stepClock();
        checkOutput("skip_out_ch", 32'(out_ch),    32'd8);
        checkOutput("skip_out",    32'(out),       32'h18);
        checkOutput("skip_valid",  32'(out_valid), 32'h1);

        // Out-of-range select on the 12-channel instance
        applyStimulus(4'd13, 16'hFFFF, 1'b0, 1'b1);
        checkOutput("bad_sel_ack12", 32'(in_ack12), 32'h0);
        checkOutput("bad_sel_ack16", 32'(in_ack),   32'h2000);
        stepClock();
        checkOutput("bad_sel_err12",   32'(sel_err12),   32'h1);
        checkOutput("bad_sel_valid12", 32'(out_valid12), 32'h0);
        checkOutput("bad_sel_err16",   32'(sel_err),     32'h0);
        checkOutput("bad_sel_ch16",    32'(out_ch),      32'd13);
        applyStimulus(4'd11, 16'hFFFF, 1'b0, 1'b1);
        stepClock();
        checkOutput("good_sel_err12",   32'(sel_err12),   32'h0);
        checkOutput("good_sel_ch12",    32'(out_ch12),    32'd11);
        checkOutput("good_sel_out12",   32'(out12),       32'h1B);
        checkOutput("good_sel_valid12", 32'(out_valid12), 32'h1);

        // Reset while a beat is stalled; scan pointer was left at 9
        applyStimulus(4'd5, 16'hFFFF, 1'b0, 1'b1);
        stepClock();
        checkOutput("pre_reset_out", 32'(out), 32'h15);
        applyStimulus(4'd5, 16'hFFFF, 1'b0, 1'b0);
        reset = 1'b1;
        stepClock();
        reset = 1'b0;
        checkOutput("stall_reset_valid", 32'(out_valid), 32'h0);
        checkOutput("stall_reset_out",   32'(out),       32'h0);
        checkOutput("stall_reset_ch",    32'(out_ch),    32'h0);
`ifdef TDM_MUX_PARITY_EN
        checkOutput("stall_reset_par",   32'(out_par),   32'h0);
`endif
        applyStimulus(4'd0, 16'hFFFF, 1'b1, 1'b1);
        stepClock();
        checkOutput("ptr_after_reset", 32'(out_ch), 32'd0);
        checkOutput("ptr_after_out",   32'(out),    32'h10);

`ifdef TDM_MUX_PARITY_EN
        lane[7] = 8'h07;
        applyStimulus(4'd7, 16'hFFFF, 1'b0, 1'b1);
        stepClock();
        checkOutput("par_out",  32'(out),     32'h07);
        checkOutput("par_bit",  32'(out_par), 32'h1);
        lane[7] = 8'h17;
        applyStimulus(4'd7, 16'hFFFF, 1'b0, 1'b1);
        stepClock();
        checkOutput("par_even", 32'(out_par), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
